// File: rtl/boot_mem_bridge_if.sv
// Memory-port bundle for boot_mem_bridge: loader byte stream, core memory
// port, unified memory port and load status. The slave side is the bridge.
interface boot_mem_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // loader byte stream
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  // core memory port
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_writedata;
  logic              cpu_memwrite;
  logic [DATA_W-1:0] cpu_readdata;
  logic              cpu_reset;
  // unified instruction/data memory
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              load_done;
  logic              load_err;
  logic [ADDR_W-1:0] load_count;

  modport slave (
    input  rx_valid, rx_data, cpu_adr, cpu_writedata, cpu_memwrite, mem_rdata,
    output rx_ready, cpu_readdata, cpu_reset, mem_adr, mem_wdata, mem_we,
           load_done, load_err, load_count
  );

  modport master (
    output rx_valid, rx_data, cpu_adr, cpu_writedata, cpu_memwrite, mem_rdata,
    input  rx_ready, cpu_readdata, cpu_reset, mem_adr, mem_wdata, mem_we,
           load_done, load_err, load_count
  );
endinterface

// File: rtl/boot_mem_bridge.sv
// Boot loader bridge: after reset it owns the memory port, writes a
// length-prefixed big-endian byte image from address 0 while holding the core
// in reset, then turns into a transparent core<->memory pass-through.
module boot_mem_bridge #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LOAD_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  boot_mem_bridge_if.slave  bus
);

  typedef enum logic [2:0] {
    CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, RUN, ERROR
  } state_e;

  localparam logic [15:0] LOAD_WORDS16 = 16'(LOAD_WORDS);

  state_e            state_q, state_d;
  logic [15:0]       n_q, n_d;          // image length in words from header
  logic [DATA_W-1:0] word_q, word_d;    // data word being assembled
  logic [ADDR_W-1:0] lc_q, lc_d;        // words written so far
  logic              cpu_reset_q, load_done_q, load_err_q;

  logic              rx_ready;
  logic              xfer;
  logic [15:0]       n_full;
  logic [ADDR_W-1:0] lc_inc;

  // Byte intake is open only in the header/data collection states.
  always_comb begin
    rx_ready = (state_q == CNT_HI) || (state_q == CNT_LO) ||
               (state_q == DAT_HI) || (state_q == DAT_LO);
  end

  assign xfer   = bus.rx_valid && rx_ready;
  assign n_full = {n_q[15:8], bus.rx_data};
  assign lc_inc = lc_q + ADDR_W'(1);

  // Next-state and datapath update; every register holds unless a byte
  // transfer or the single WRITE cycle moves it.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    word_d  = word_q;
    lc_d    = lc_q;
    unique case (state_q)
      CNT_HI: if (xfer) begin
        n_d[15:8] = bus.rx_data;
        state_d   = CNT_LO;
      end
      CNT_LO: if (xfer) begin
        n_d[7:0] = bus.rx_data;
        if (n_full == 16'd0)              state_d = RUN;
        else if (n_full > LOAD_WORDS16)   state_d = ERROR;
        else                              state_d = DAT_HI;
      end
      DAT_HI: if (xfer) begin
        word_d[15:8] = bus.rx_data;
        state_d      = DAT_LO;
      end
      DAT_LO: if (xfer) begin
        word_d[7:0] = bus.rx_data;
        state_d     = WRITE;
      end
      WRITE: begin
        lc_d    = lc_inc;
        state_d = (16'(lc_inc) == n_q) ? RUN : DAT_HI;
      end
      RUN:     state_d = RUN;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  // FSM state, datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CNT_HI;
      n_q         <= '0;
      word_q      <= '0;
      lc_q        <= '0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      word_q      <= word_d;
      lc_q        <= lc_d;
      cpu_reset_q <= (state_d != RUN);
      load_done_q <= (state_d == RUN);
      load_err_q  <= (state_d == ERROR);
    end
  end

  // Memory port mux: the core only reaches memory once RUN is entered, so a
  // core store during load can never land.
  always_comb begin
    bus.mem_adr   = lc_q;
    bus.mem_wdata = word_q;
    bus.mem_we    = 1'b0;
    if (state_q == RUN) begin
      bus.mem_adr   = bus.cpu_adr;
      bus.mem_wdata = bus.cpu_writedata;
      bus.mem_we    = bus.cpu_memwrite;
    end else if (state_q == WRITE) begin
      bus.mem_we    = 1'b1;
    end
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.cpu_readdata = bus.mem_rdata;
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.load_done    = load_done_q;
  assign bus.load_err     = load_err_q;
  assign bus.load_count   = lc_q;

endmodule

// File: doc/boot_mem_bridge.md
Name: boot_mem_bridge

Overview:
Sits between the processor core's memory port (adr, writedata, memwrite, readdata) and the unified 16-bit instruction/data memory.
- After reset it owns the memory port and holds the core in reset.
- It receives a program image as a byte stream and writes it to memory from address 0.
- It then releases the core and becomes a transparent pass-through for core memory traffic.

Parameters:
ADDR_W, 16, memory/core address width
DATA_W, 16, memory word width (fixed two bytes per word)
LOAD_WORDS, 256, maximum image length in words; larger headers are an error

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
rx_valid  input  1  loader byte valid
rx_data  input  8  loader byte
rx_ready  output  1  bridge accepts byte this cycle
cpu_adr  input  ADDR_W  core memory address
cpu_writedata  input  DATA_W  core store data
cpu_memwrite  input  1  core store strobe
cpu_readdata  output  DATA_W  read data to core
cpu_reset  output  1  active-high reset to core, registered
mem_adr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_we  output  1  memory write enable
mem_rdata  input  DATA_W  memory read data
load_done  output  1  image loaded, core running
load_err  output  1  header exceeded LOAD_WORDS
load_count  output  ADDR_W  words written so far

Behaviour:
- Byte transfer occurs on a rising edge with rx_valid && rx_ready. rx_data is sampled only then. rx_valid is ignored when rx_ready=0.
- State machine: CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, RUN, ERROR.
- Reset (reset=0, async) forces:
  - state=CNT_HI, cpu_reset=1, load_done=0, load_err=0, load_count=0;
  - word count N=0, assembly registers=0, mem_we=0.
- CNT_HI: rx_ready=1. On transfer, N[15:8]=byte, go to CNT_LO.
- CNT_LO: rx_ready=1. On transfer, N[7:0]=byte, then:
  - full N==0 → RUN;
  - full N>LOAD_WORDS → ERROR;
  - otherwise → DAT_HI.
- DAT_HI: rx_ready=1. On transfer, word[15:8]=byte, go to DAT_LO.
- DAT_LO: rx_ready=1. On transfer, word[7:0]=byte, go to WRITE.
- WRITE (exactly one cycle): rx_ready=0, mem_we=1, mem_adr=load_count, mem_wdata=assembled word. At the edge leaving WRITE, load_count increments. Next state is RUN if load_count+1==N, else DAT_HI.
- RUN:
  - rx_ready=0;
  - mem_adr=cpu_adr, mem_wdata=cpu_writedata, mem_we=cpu_memwrite, all combinational;
  - load_done=1;
  - load_count frozen at N.
- ERROR: rx_ready=0, mem_we=0, load_err=1, cpu_reset=1. Exit only via reset.
- cpu_reset is a register equal to (next_state != RUN). It deasserts on the same edge the FSM enters RUN and never reasserts without reset.
- cpu_readdata = mem_rdata at all times (combinational). The core is in reset while loading, so its reads are don't-care.
- While not in RUN, cpu_memwrite, cpu_adr and cpu_writedata are ignored. A core store can never reach memory during load.
- During CNT_*/DAT_* states: mem_we=0; mem_adr=load_count; mem_wdata=assembled word.
- Stalls: gaps in rx_valid of any length are legal. The FSM holds state and all registers.
- Reset asserted mid-load aborts immediately. Words already written stay in memory. The next image restarts at address 0.
- Widths: N is 16 bits. The comparison with LOAD_WORDS is unsigned. load_count never wraps because N≤LOAD_WORDS<2^ADDR_W.

Test Plan:
- Reset then bytes 00 02 12 34 AB CD with rx_valid held high → mem_we pulses twice: adr 0 data 0x1234, then adr 1 data 0xABCD. cpu_reset falls on the edge after the second WRITE; load_done=1; load_count=2.
- Header 00 00 → RUN two transfers after reset; no mem_we pulse; cpu_reset=0; load_done=1.
- Header 01 01 (257 > 256) → load_err=1, rx_ready=0, cpu_reset stays 1. Further rx_valid bytes cause no writes.
- Load 1 word with rx_valid toggling every other cycle, and cpu_memwrite=1, cpu_adr=0x0005 held throughout → mem_we only at adr 0 during load. After RUN, mem_adr=0x0005 and mem_we=1 follow the core.
- Assert reset after header 00 03 plus one data word → all outputs at reset values. Reload 00 01 55 AA → write adr 0 data 0x55AA, then RUN.
- In RUN, mem_rdata=0xBEEF → cpu_readdata=0xBEEF in the same cycle; rx_valid=1 yields rx_ready=0 and no state change.
